// File: rtl/imm_extend_unit_pkg.sv
// Shared pipeline definitions: immediate extension mode encodings used by the
// instruction decoder and the immediate extension unit.
package imm_extend_unit_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_SIGN   = 3'b000,
        MODE_ZERO   = 3'b001,
        MODE_UPPER  = 3'b010,
        MODE_BRANCH = 3'b011,
        MODE_BYTE   = 3'b100
    } imm_mode_e;

    // True for the five defined encodings; 101-111 are reserved.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
        return mode <= MODE_W'(MODE_BYTE);
    endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: widens a raw instruction immediate
// according to the selected mode and flags reserved mode encodings.
module imm_extend_core
    import imm_extend_unit_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic [OUT_W-1:0]  imm,
    output logic              err
);

    localparam int unsigned EXT_W  = OUT_W - IN_W;
    localparam int unsigned BYTE_W = 8;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;
    logic [OUT_W-1:0] byte_ext;

    assign sign_ext   = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    assign zero_ext   = {{EXT_W{1'b0}}, in_imm};
    assign upper_ext  = {in_imm, {EXT_W{1'b0}}};
    // Word-aligned branch offset: the top two sign bits fall off the end.
    assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};
    assign byte_ext   = {{(OUT_W-BYTE_W){in_imm[BYTE_W-1]}}, in_imm[BYTE_W-1:0]};

    always_comb begin
        imm = '0;
        err = !mode_is_legal(in_mode);
        case (imm_mode_e'(in_mode))
            MODE_SIGN:   imm = sign_ext;
            MODE_ZERO:   imm = zero_ext;
            MODE_UPPER:  imm = upper_ext;
            MODE_BRANCH: imm = branch_ext;
            MODE_BYTE:   imm = byte_ext;
            default:     imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extension unit: extends the immediate ahead of the first register,
// then carries valid/imm/err through STAGES stall- and flush-aware registers.
module imm_extend_unit
    import imm_extend_unit_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_imm,
    output logic              out_err
);

    localparam int unsigned LAST = STAGES - 1;

    logic [OUT_W-1:0] ext_imm;
    logic             ext_err;

    logic             valid_q [STAGES];
    logic [OUT_W-1:0] imm_q   [STAGES];
    logic             err_q   [STAGES];
    logic             valid_d [STAGES];
    logic [OUT_W-1:0] imm_d   [STAGES];
    logic             err_d   [STAGES];

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm  (in_imm),
        .in_mode (in_mode),
        .imm     (ext_imm),
        .err     (ext_err)
    );

    // Next stage contents: flush kills valids only, stall holds everything.
    always_comb begin
        valid_d = valid_q;
        imm_d   = imm_q;
        err_d   = err_q;
        if (flush) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (!stall) begin
            valid_d[0] = in_valid;
            imm_d[0]   = ext_imm;
            err_d[0]   = ext_err;
            for (int unsigned i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                imm_d[i]   = imm_q[i-1];
                err_d[i]   = err_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                imm_q[i]   <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign out_imm   = imm_q[LAST];
    assign out_err   = err_q[LAST];

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: one-stage and two-stage instances share stimulus;
// a per-instance scoreboard tracks expected outputs by advancing-edge count.
module tb_imm_extend_unit;
    import imm_extend_unit_pkg::*;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] imm;
        logic [31:0] exp_imm;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic        err;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic        o1_valid, o1_err, o2_valid, o2_err;
    logic [31:0] o1_imm, o2_imm;

    logic [31:0] drv_exp_imm;
    logic        drv_exp_err;

    sb_t         q1[$], q2[$];
    sb_t         e1, e2;
    logic        ev1 = 1'b0, ev2 = 1'b0, ez1 = 1'b0, ez2 = 1'b0;
    int          adv = 0;
    bit          started = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    vec_t        vecs[14];

    always #5 clk = ~clk;

    imm_extend_unit #(.IN_W(16), .OUT_W(32), .STAGES(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm),
        .in_mode(in_mode), .stall(stall), .flush(flush),
        .out_valid(o1_valid), .out_imm(o1_imm), .out_err(o1_err)
    );

    imm_extend_unit #(.IN_W(16), .OUT_W(32), .STAGES(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm),
        .in_mode(in_mode), .stall(stall), .flush(flush),
        .out_valid(o2_valid), .out_imm(o2_imm), .out_err(o2_err)
    );

    // Reference extension written directly from the mode definitions.
    function automatic logic [32:0] ref_ext(input logic [2:0] mode, input logic [15:0] imm);
        logic [31:0] se;
        se = {{16{imm[15]}}, imm};
        case (mode)
            3'b000:  return {1'b0, se};
            3'b001:  return {1'b0, 16'h0000, imm};
            3'b010:  return {1'b0, imm, 16'h0000};
            3'b011:  return {1'b0, se[29:0], 2'b00};
            3'b100:  return {1'b0, {24{imm[7]}}, imm[7:0]};
            default: return {1'b1, 32'h0000_0000};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] mode, input logic [15:0] imm,
                         input logic st, input logic fl);
        logic [32:0] r;
        r           = ref_ext(mode, imm);
        in_valid    = v;
        in_mode     = mode;
        in_imm      = imm;
        stall       = st;
        flush       = fl;
        drv_exp_imm = r[31:0];
        drv_exp_err = r[32];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: entries become due a fixed number of advancing edges after capture.
    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            q1.delete(); q2.delete();
            ev1 = 1'b0; ev2 = 1'b0; ez1 = 1'b1; ez2 = 1'b1;
        end else if (flush) begin
            q1.delete(); q2.delete();
            ev1 = 1'b0; ev2 = 1'b0;
        end else if (!stall) begin
            adv++;
            ez1 = 1'b0; ez2 = 1'b0;
            if (in_valid) begin
                q1.push_back('{drv_exp_imm, drv_exp_err, adv});
                q2.push_back('{drv_exp_imm, drv_exp_err, adv + 1});
            end
            if (q1.size() > 0 && q1[0].due == adv) begin e1 = q1.pop_front(); ev1 = 1'b1; end
            else ev1 = 1'b0;
            if (q2.size() > 0 && q2[0].due == adv) begin e2 = q2.pop_front(); ev2 = 1'b1; end
            else ev2 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("s1_valid", 32'(o1_valid), 32'(ev1));
            chk("s2_valid", 32'(o2_valid), 32'(ev2));
            if (ev1) begin chk("s1_imm", o1_imm, e1.imm); chk("s1_err", 32'(o1_err), 32'(e1.err)); end
            if (ev2) begin chk("s2_imm", o2_imm, e2.imm); chk("s2_err", 32'(o2_err), 32'(e2.err)); end
            if (ez1) begin chk("s1_rst_imm", o1_imm, 32'h0); chk("s1_rst_err", 32'(o1_err), 32'h0); end
            if (ez2) begin chk("s2_rst_imm", o2_imm, 32'h0); chk("s2_rst_err", 32'(o2_err), 32'h0); end
        end
    end

    initial begin
        int cnt;
        vecs[0]  = '{3'b000, 16'h8000, 32'hFFFF_8000, 1'b0};
        vecs[1]  = '{3'b001, 16'h8000, 32'h0000_8000, 1'b0};
        vecs[2]  = '{3'b010, 16'h1234, 32'h1234_0000, 1'b0};
        vecs[3]  = '{3'b011, 16'hFFFF, 32'hFFFF_FFFC, 1'b0};
        vecs[4]  = '{3'b100, 16'h1280, 32'hFFFF_FF80, 1'b0};
        vecs[5]  = '{3'b110, 16'h7FFF, 32'h0000_0000, 1'b1};
        vecs[6]  = '{3'b101, 16'h0001, 32'h0000_0000, 1'b1};
        vecs[7]  = '{3'b111, 16'hFFFF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{3'b000, 16'h7FFF, 32'h0000_7FFF, 1'b0};
        vecs[9]  = '{3'b011, 16'h4000, 32'h0001_0000, 1'b0};
        vecs[10] = '{3'b011, 16'h8001, 32'hFFFE_0004, 1'b0};
        vecs[11] = '{3'b100, 16'h007F, 32'h0000_007F, 1'b0};
        vecs[12] = '{3'b001, 16'hFFFF, 32'h0000_FFFF, 1'b0};
        vecs[13] = '{3'b010, 16'hFFFF, 32'hFFFF_0000, 1'b0};

        reset = 1'b1;
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        step(); step();
        chk("rst_valid1", 32'(o1_valid), 32'h0);
        chk("rst_valid2", 32'(o2_valid), 32'h0);
        chk("rst_imm2", o2_imm, 32'h0);
        reset = 1'b0;

        // Back-to-back table vectors; the scoreboard carries the table's expectations.
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].imm, 1'b0, 1'b0);
            drv_exp_imm = vecs[i].exp_imm;
            drv_exp_err = vecs[i].exp_err;
            step();
        end
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        step(); step(); step();

        // Stall while the entry is in flight: it must appear exactly once on the 2-stage output.
        cnt = 0;
        drive(1'b1, MODE_SIGN, 16'h0001, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, MODE_SIGN, 16'(16'h0100 + i), 1'b1, 1'b0);
            step();
            chk("stall_hold1", o1_imm, 32'h0000_0001);
            if (o2_valid && o2_imm == 32'h1) cnt++;
        end
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (o2_valid && o2_imm == 32'h1) cnt++;
        end
        chk("stall_once", 32'(cnt), 32'd1);

        // Flush with stall and two entries in flight: nothing may reappear.
        drive(1'b1, MODE_ZERO, 16'h00A1, 1'b0, 1'b0); step();
        drive(1'b1, MODE_ZERO, 16'h00A2, 1'b0, 1'b0); step();
        drive(1'b1, MODE_ZERO, 16'h00A3, 1'b1, 1'b1); step();
        chk("flush_v2", 32'(o2_valid), 32'h0);
        chk("flush_v1", 32'(o1_valid), 32'h0);
        cnt = 0;
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (o1_valid || o2_valid) cnt++;
        end
        chk("flush_none", 32'(cnt), 32'd0);

        // Reset for one cycle mid-flight, then check first post-reset latency.
        drive(1'b1, MODE_ZERO, 16'h00AA, 1'b0, 1'b0); step();
        reset = 1'b1;
        drive(1'b1, MODE_SIGN, 16'h5555, 1'b0, 1'b0); step();
        chk("midrst_v2", 32'(o2_valid), 32'h0);
        chk("midrst_imm2", o2_imm, 32'h0);
        chk("midrst_v1", 32'(o1_valid), 32'h0);
        reset = 1'b0;
        drive(1'b1, MODE_UPPER, 16'h00C3, 1'b0, 1'b0); step();
        chk("post_rst1", o1_imm, 32'h00C3_0000);
        chk("post_rst_v2", 32'(o2_valid), 32'h0);
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0); step();
        chk("post_rst2", o2_imm, 32'h00C3_0000);
        chk("post_rst_v2b", 32'(o2_valid), 32'h1);

        // Random traffic with occasional stall and flush.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
            step();
        end
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("drain1", 32'(q1.size()), 32'h0);
        chk("drain2", 32'(q2.size()), 32'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
